control_sequencer: RTL and testbench

- Hard-wired control unit directly upstream of the CPU datapath.
- Replaces the hand-driven control signals currently used in datapath benches.
- Runs the fetch cycle (T0–T2), decodes the IR, then runs the execute steps for register ALU, immediate ALU, mul/div, unary, nop and halt instructions.
- Register selection is encoded: it drives Gra/Grb/Grc/Rin/Rout to the datapath's select-and-encode logic.

---
 rtl/control_sequencer.sv | 158 +++++++++++++++
 tb/tb_control_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hard-wired Moore control sequencer: fetch (T0-T2), decode, then per-class execute steps.
// Outputs are a pure decode of the present state and the opcode latched on T3 entry.
module control_sequencer #(
  parameter int unsigned OPW = 5,
  parameter int unsigned IRW = 32
) (
  input  logic           Clock,
  input  logic           Clear,
  input  logic [IRW-1:0] IR,
  input  logic           Stop,
  output logic           PCout,
  output logic           Zlowout,
  output logic           ZHighout,
  output logic           MDRout,
  output logic           MARin,
  output logic           PCin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Yin,
  output logic           ZLowIn,
  output logic           ZHighIn,
  output logic           HIin,
  output logic           LOin,
  output logic           IncPC,
  output logic           Read,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic           Cout,
  output logic [OPW-1:0] ALUop,
  output logic           Run
);

  localparam logic [3:0] StRst  = 4'd0;
  localparam logic [3:0] StT0   = 4'd1;
  localparam logic [3:0] StT1   = 4'd2;
  localparam logic [3:0] StT2   = 4'd3;
  localparam logic [3:0] StT3   = 4'd4;
  localparam logic [3:0] StT4   = 4'd5;
  localparam logic [3:0] StT5   = 4'd6;
  localparam logic [3:0] StT6   = 4'd7;
  localparam logic [3:0] StHalt = 4'd8;

  localparam logic [OPW-1:0] OpAdd  = 5'b00011;
  localparam logic [OPW-1:0] OpOr   = 5'b01010;
  localparam logic [OPW-1:0] OpAddi = 5'b01011;
  localparam logic [OPW-1:0] OpAndi = 5'b01100;
  localparam logic [OPW-1:0] OpOri  = 5'b01101;
  localparam logic [OPW-1:0] OpMul  = 5'b01110;
  localparam logic [OPW-1:0] OpDiv  = 5'b01111;
  localparam logic [OPW-1:0] OpNeg  = 5'b10000;
  localparam logic [OPW-1:0] OpNot  = 5'b10001;
  localparam logic [OPW-1:0] OpHalt = 5'b11011;

  logic [3:0]     state_q, state_d;
  logic [OPW-1:0] op_q, op_d;

  logic is_alu3, is_imm, is_muldiv, is_unary, is_halt;
  logic [OPW-1:0] imm_aluop;

  always_comb begin
    is_alu3   = (op_q >= OpAdd) && (op_q <= OpOr);
    is_imm    = (op_q == OpAddi) || (op_q == OpAndi) || (op_q == OpOri);
    is_muldiv = (op_q == OpMul) || (op_q == OpDiv);
    is_unary  = (op_q == OpNeg) || (op_q == OpNot);
    is_halt   = (op_q == OpHalt);
    unique case (op_q)
      OpAddi:  imm_aluop = 5'b00011;
      OpAndi:  imm_aluop = 5'b01001;
      default: imm_aluop = 5'b01010;
    endcase
  end

  // Leaving the last execute state is the only point where Stop is honoured.
  logic [3:0] end_state;
  assign end_state = Stop ? StHalt : StT0;

  always_comb begin
    state_d = StRst;
    op_d    = op_q;
    unique case (state_q)
      StRst:  state_d = StT0;
      StT0:   state_d = StT1;
      StT1:   state_d = StT2;
      StT2: begin
        state_d = StT3;
        op_d    = IR[IRW-1 -: OPW];
      end
      StT3: begin
        if (is_halt)                                     state_d = StHalt;
        else if (is_alu3 || is_imm || is_muldiv || is_unary) state_d = StT4;
        else                                             state_d = end_state;
      end
      StT4:   state_d = is_unary ? end_state : StT5;
      StT5:   state_d = is_muldiv ? StT6 : end_state;
      StT6:   state_d = end_state;
      StHalt: state_d = StHalt;
      default: state_d = StRst;
    endcase
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_q <= StRst;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    PCout = 1'b0; Zlowout = 1'b0; ZHighout = 1'b0; MDRout = 1'b0;
    MARin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0;
    ZLowIn = 1'b0; ZHighIn = 1'b0; HIin = 1'b0; LOin = 1'b0;
    IncPC = 1'b0; Read = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; Cout = 1'b0;
    ALUop = '0;
    Run = (state_q != StHalt);
    unique case (state_q)
      StT0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
      StT1: begin Read = 1'b1; MDRin = 1'b1; end
      StT2: begin MDRout = 1'b1; IRin = 1'b1; end
      StT3: begin
        if (is_alu3 || is_imm) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (is_muldiv) begin
          Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (is_unary) begin
          Grb = 1'b1; Rout = 1'b1; ALUop = op_q; ZLowIn = 1'b1; ZHighIn = 1'b1;
        end
      end
      StT4: begin
        if (is_alu3) begin
          Grc = 1'b1; Rout = 1'b1; ALUop = op_q; ZLowIn = 1'b1; ZHighIn = 1'b1;
        end else if (is_imm) begin
          Cout = 1'b1; ALUop = imm_aluop; ZLowIn = 1'b1; ZHighIn = 1'b1;
        end else if (is_muldiv) begin
          Grb = 1'b1; Rout = 1'b1; ALUop = op_q; ZLowIn = 1'b1; ZHighIn = 1'b1;
        end else if (is_unary) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end
      end
      StT5: begin
        if (is_muldiv) begin
          Zlowout = 1'b1; LOin = 1'b1;
        end else begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end
      end
      StT6: begin ZHighout = 1'b1; HIin = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle expected strobe vectors are queued
// from the instruction tables and compared at each falling edge.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Clear = 1'b1;
  logic [31:0] IR = '0;
  logic        Stop = 1'b0;
  logic PCout, Zlowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin, Yin;
  logic ZLowIn, ZHighIn, HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout, Cout, Run;
  logic [4:0] ALUop;

  int errors = 0;
  int checks = 0;
  logic [26:0] exp_q[$];

  control_sequencer dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .Stop(Stop),
    .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout), .MDRout(MDRout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .HIin(HIin), .LOin(LOin),
    .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .Cout(Cout), .ALUop(ALUop), .Run(Run)
  );

  always #5 Clock = ~Clock;

  localparam logic [26:0] RUN   = 27'(1);
  localparam logic [26:0] COUT  = 27'(1) << 6;
  localparam logic [26:0] ROUT  = 27'(1) << 7;
  localparam logic [26:0] RIN   = 27'(1) << 8;
  localparam logic [26:0] GRC   = 27'(1) << 9;
  localparam logic [26:0] GRB   = 27'(1) << 10;
  localparam logic [26:0] GRA   = 27'(1) << 11;
  localparam logic [26:0] READ  = 27'(1) << 12;
  localparam logic [26:0] INCPC = 27'(1) << 13;
  localparam logic [26:0] LOIN  = 27'(1) << 14;
  localparam logic [26:0] HIIN  = 27'(1) << 15;
  localparam logic [26:0] ZHI   = 27'(1) << 16;
  localparam logic [26:0] ZLI   = 27'(1) << 17;
  localparam logic [26:0] YIN   = 27'(1) << 18;
  localparam logic [26:0] IRIN  = 27'(1) << 19;
  localparam logic [26:0] MDRIN = 27'(1) << 20;
  localparam logic [26:0] PCIN  = 27'(1) << 21;
  localparam logic [26:0] MARIN = 27'(1) << 22;
  localparam logic [26:0] MDRO  = 27'(1) << 23;
  localparam logic [26:0] ZHO   = 27'(1) << 24;
  localparam logic [26:0] ZLO   = 27'(1) << 25;
  localparam logic [26:0] PCO   = 27'(1) << 26;

  logic [26:0] dut_vec;
  assign dut_vec = {PCout, Zlowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin, Yin,
                    ZLowIn, ZHighIn, HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout,
                    Cout, ALUop, Run};

  function automatic logic [26:0] aluv(input logic [4:0] op);
    return {21'b0, op, 1'b0};
  endfunction

  // Structural invariants, sampled every falling edge.
  always @(negedge Clock) begin
    checks++;
    if ($countones({PCout, Zlowout, ZHighout, MDRout, Rout, Cout}) > 1) begin
      errors++;
      $display("FAIL bus_onehot: drivers=%b required at most one high",
               {PCout, Zlowout, ZHighout, MDRout, Rout, Cout});
    end
    checks++;
    if (!ZLowIn && ALUop !== 5'b0) begin
      errors++;
      $display("FAIL aluop_idle: ALUop=%b required 00000 with ZLowIn=0", ALUop);
    end
    checks++;
    if ((Rin || Rout) ? ($countones({Gra, Grb, Grc}) != 1) : ({Gra, Grb, Grc} != 3'b0)) begin
      errors++;
      $display("FAIL gr_select: GraGrbGrc=%b with Rin=%b Rout=%b", {Gra, Grb, Grc}, Rin, Rout);
    end
  end

  task automatic push_instr(input logic [4:0] op, input bit halt_after, input int n_halt);
    exp_q.push_back(PCO | MARIN | INCPC | RUN);
    exp_q.push_back(READ | MDRIN | RUN);
    exp_q.push_back(MDRO | IRIN | RUN);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b01010: begin
        exp_q.push_back(GRB | ROUT | YIN | RUN);
        exp_q.push_back(GRC | ROUT | aluv(op) | ZLI | ZHI | RUN);
        exp_q.push_back(ZLO | GRA | RIN | RUN);
      end
      5'b01011: begin
        exp_q.push_back(GRB | ROUT | YIN | RUN);
        exp_q.push_back(COUT | aluv(5'b00011) | ZLI | ZHI | RUN);
        exp_q.push_back(ZLO | GRA | RIN | RUN);
      end
      5'b01100: begin
        exp_q.push_back(GRB | ROUT | YIN | RUN);
        exp_q.push_back(COUT | aluv(5'b01001) | ZLI | ZHI | RUN);
        exp_q.push_back(ZLO | GRA | RIN | RUN);
      end
      5'b01101: begin
        exp_q.push_back(GRB | ROUT | YIN | RUN);
        exp_q.push_back(COUT | aluv(5'b01010) | ZLI | ZHI | RUN);
        exp_q.push_back(ZLO | GRA | RIN | RUN);
      end
      5'b01110, 5'b01111: begin
        exp_q.push_back(GRA | ROUT | YIN | RUN);
        exp_q.push_back(GRB | ROUT | aluv(op) | ZLI | ZHI | RUN);
        exp_q.push_back(ZLO | LOIN | RUN);
        exp_q.push_back(ZHO | HIIN | RUN);
      end
      5'b10000, 5'b10001: begin
        exp_q.push_back(GRB | ROUT | aluv(op) | ZLI | ZHI | RUN);
        exp_q.push_back(ZLO | GRA | RIN | RUN);
      end
      default: exp_q.push_back(RUN);
    endcase
    if (halt_after) for (int i = 0; i < n_halt; i++) exp_q.push_back(27'b0);
  endtask

  // Pops and compares one vector per cycle; optionally raises Stop after cycle stop_idx
  // and toggles Stop on every cycle from toggle_idx onwards.
  task automatic consume(input string name, input int limit, input int stop_idx,
                         input int toggle_idx);
    logic [26:0] e;
    int i = 0;
    while (exp_q.size() > 0 && i < limit) begin
      @(negedge Clock);
      e = exp_q.pop_front();
      checks++;
      if (dut_vec !== e) begin
        errors++;
        $display("FAIL %s cycle %0d: got %b required %b", name, i, dut_vec, e);
      end
      if (i == stop_idx) Stop = 1'b1;
      if (toggle_idx >= 0 && i >= toggle_idx) Stop = ~Stop;
      i++;
    end
    exp_q.delete();
  endtask

  task automatic do_clear();
    @(negedge Clock);
    Clear = 1'b1;
    Stop  = 1'b0;
    @(negedge Clock);
    Clear = 1'b0;
  endtask

  task automatic test_reset();
    Clear = 1'b1;
    repeat (2) @(negedge Clock);
    checks++;
    if (dut_vec !== RUN) begin
      errors++;
      $display("FAIL reset_state: got %b required %b", dut_vec, RUN);
    end
    Clear = 1'b0;
    IR = 32'h18000000;
    push_instr(5'b00011, 1'b0, 0);
    consume("add_pre_clear", 5, -1, -1);
    Clear = 1'b1;
    #1;
    checks++;
    if (dut_vec !== RUN) begin
      errors++;
      $display("FAIL clear_mid_t4: got %b required %b", dut_vec, RUN);
    end
    @(negedge Clock);
    Clear = 1'b0;
  endtask

  task automatic test_instr(input string name, input logic [31:0] ir);
    IR = ir;
    push_instr(ir[31:27], 1'b0, 0);
    consume(name, 100, -1, -1);
  endtask

  task automatic test_stop_and();
    IR = 32'h48000000;
    push_instr(5'b01001, 1'b1, 5);
    consume("and_stop", 100, 1, -1);
    do_clear();
  endtask

  task automatic test_halt();
    IR = 32'hD8000000;
    push_instr(5'b11011, 1'b1, 20);
    consume("halt", 100, -1, 4);
    Stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_instr("shr", 32'h2A920000);
    test_instr("mul", 32'h71880000);
    test_instr("div", 32'h78000000);
    test_instr("addi", 32'h5A900000);
    test_instr("ori", 32'h68000000);
    test_instr("nop", 32'hD0000000);
    test_instr("undef", 32'hF8000000);
    test_instr("neg", 32'h81100000);
    test_instr("back_to_back_add", 32'h18000000);
    test_stop_and();
    test_instr("after_clear_not", 32'h88000000);
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
